// File: rtl/bcd_binario_if.sv
// Request and result signals of the BCD-to-binary converter.
// The requester drives the start strobe and the eight BCD digits.
// The converter returns the binary value together with its status flags.
interface bcd_binario_if;
    logic        iniciar;
    logic [3:0]  unidade;
    logic [3:0]  dezena;
    logic [3:0]  centena;
    logic [3:0]  milhar;
    logic [3:0]  d_milhar;
    logic [3:0]  c_milhar;
    logic [3:0]  milhao;
    logic [3:0]  d_milhao;
    logic [31:0] binario;
    logic        ocupado;
    logic        pronto;
    logic        erro;

    modport master (
        output iniciar, unidade, dezena, centena, milhar,
               d_milhar, c_milhar, milhao, d_milhao,
        input  binario, ocupado, pronto, erro
    );

    modport slave (
        input  iniciar, unidade, dezena, centena, milhar,
               d_milhar, c_milhar, milhao, d_milhao,
        output binario, ocupado, pronto, erro
    );
endinterface

// File: rtl/bcd_binario.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each clock shifts one bit out of the BCD register into the top of the
// accumulator. After the shift, any digit that is 8 or more has 3 subtracted.
// After 32 steps the accumulator holds the binary value.
//
// state    | meaning
// ---------+------------------------------------------------------------
// OCIOSO   | idle; samples iniciar and the digits, checks digit validity
// CONVERTE | one shift/correct step per clock, 32 steps
// FIM      | one-cycle result strobe (pronto); binario/erro just loaded
module bcd_binario (
    input  logic clock,
    input  logic reset,
    bcd_binario_if.slave io
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] bcd_q, bcd_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] binario_q, binario_d;
    logic        erro_q, erro_d;

    logic [31:0] digitos;
    logic        entrada_invalida;

    assign digitos = {io.d_milhao, io.milhao, io.c_milhar, io.d_milhar,
                      io.milhar, io.centena, io.dezena, io.unidade};

    // Subtract 3 from every nibble that is 8 or more. This undoes the
    // half-decade carry that the right shift pushed into that digit.
    function automatic logic [31:0] corrige(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            if (r[4*i +: 4] >= 4'd8) begin
                r[4*i +: 4] = r[4*i +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    // True when any nibble is outside the BCD range 0..9.
    function automatic logic tem_invalido(input logic [31:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign entrada_invalida = tem_invalido(digitos);

    // State register and datapath registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            bcd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            binario_q <= '0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            binario_q <= binario_d;
            erro_q    <= erro_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        estado_d  = estado_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        binario_d = binario_q;
        erro_d    = erro_q;

        case (estado_q)
            OCIOSO: begin
                if (io.iniciar) begin
                    bcd_d = digitos;
                    acc_d = '0;
                    cnt_d = '0;
                    if (entrada_invalida) begin
                        binario_d = '0;
                        erro_d    = 1'b1;
                        estado_d  = FIM;
                    end else begin
                        estado_d  = CONVERTE;
                    end
                end
            end

            CONVERTE: begin
                acc_d = {bcd_q[0], acc_q[31:1]};
                bcd_d = corrige({1'b0, bcd_q[31:1]});
                cnt_d = cnt_q + 6'd1;
                // The last step publishes the accumulator it has just
                // produced. That way binario never shows a partial value.
                if (cnt_q == 6'd31) begin
                    binario_d = acc_d;
                    erro_d    = 1'b0;
                    estado_d  = FIM;
                end
            end

            FIM: begin
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign io.binario = binario_q;
    assign io.erro    = erro_q;
    assign io.ocupado = (estado_q != OCIOSO);
    assign io.pronto  = (estado_q == FIM);

endmodule

// File: tb/tb_bcd_binario.sv
// Directed bench for bcd_binario. Expected values are hand-computed decimal-to-hex conversions.
module tb_bcd_binario;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bcd_binario_if bus ();

    bcd_binario dut (
        .clock (clk),
        .reset (rst),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] d);
        bus.d_milhao = d[31:28];
        bus.milhao   = d[27:24];
        bus.c_milhar = d[23:20];
        bus.d_milhar = d[19:16];
        bus.milhar   = d[15:12];
        bus.centena  = d[11:8];
        bus.dezena   = d[7:4];
        bus.unidade  = d[3:0];
    endtask

    // One-cycle request. Latency is counted in cycles after the sampling edge.
    task automatic run(input string tag, input logic [31:0] d, input logic [31:0] exp_bin,
                       input logic exp_err, input int exp_lat);
        int lat;
        load(d);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        check({tag, "_ocupado_start"}, {31'd0, bus.ocupado}, 32'd1);
        lat = 1;
        while (!bus.pronto && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_binario"}, bus.binario, exp_bin);
        check({tag, "_erro"}, {31'd0, bus.erro}, {31'd0, exp_err});
        check({tag, "_ocupado_fim"}, {31'd0, bus.ocupado}, 32'd1);
        tick();
        check({tag, "_pronto_pulse"}, {31'd0, bus.pronto}, 32'd0);
        check({tag, "_ocupado_idle"}, {31'd0, bus.ocupado}, 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        int seen;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.iniciar = 1'b0;
        load(32'h0000_0000);
        tick();
        tick();
        check("reset_binario", bus.binario, 32'd0);
        check("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        check("reset_pronto", {31'd0, bus.pronto}, 32'd0);
        check("reset_erro", {31'd0, bus.erro}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic conversions, including the extremes of the range.
        run("d12345678", 32'h1234_5678, 32'h00BC_614E, 1'b0, 33);
        run("d99999999", 32'h9999_9999, 32'h05F5_E0FF, 1'b0, 33);
        run("d00000000", 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
        run("d00000001", 32'h0000_0001, 32'h0000_0001, 1'b0, 33);

        // An invalid digit finishes at once with erro. A valid request then clears erro.
        run("dezena_A", 32'h1234_56A8, 32'h0000_0000, 1'b1, 1);
        repeat (5) tick();
        check("erro_hold", {31'd0, bus.erro}, 32'd1);
        check("erro_hold_binario", bus.binario, 32'd0);
        run("d00000042", 32'h0000_0042, 32'h0000_002A, 1'b0, 33);

        // iniciar held high. The digits change right after the first capture.
        load(32'h1234_5678);
        bus.iniciar = 1'b1;
        tick();
        load(32'h9999_9999);
        lat = 1;
        while (!bus.pronto && lat < 200) begin
            tick();
            lat++;
        end
        check("held_first_latency", lat, 33);
        check("held_first_binario", bus.binario, 32'h00BC_614E);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!bus.pronto && gap < 200);
        check("held_pronto_spacing", gap, 34);
        check("held_second_binario", bus.binario, 32'h05F5_E0FF);
        check("held_second_erro", {31'd0, bus.erro}, 32'd0);
        bus.iniciar = 1'b0;
        tick();
        tick();
        check("held_idle_ocupado", {31'd0, bus.ocupado}, 32'd0);

        // Reset partway through a conversion.
        load(32'h1234_5678);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        repeat (14) tick();
        check("midreset_busy", {31'd0, bus.ocupado}, 32'd1);
        rst = 1'b1;
        tick();
        check("midreset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        check("midreset_pronto", {31'd0, bus.pronto}, 32'd0);
        check("midreset_binario", bus.binario, 32'd0);
        check("midreset_erro", {31'd0, bus.erro}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.pronto) seen++;
        end
        check("midreset_no_pronto", seen, 0);
        run("d87654321", 32'h8765_4321, 32'h0539_7FB1, 1'b0, 33);

        // An idle converter holds its last result.
        seen = 0;
        repeat (5) begin
            repeat (10) begin
                tick();
                if (bus.pronto) seen++;
            end
            check("idle_binario", bus.binario, 32'h0539_7FB1);
            check("idle_erro", {31'd0, bus.erro}, 32'd0);
        end
        check("idle_no_pronto", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
